// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard controller.
// Build option: define PS2_KBD_ASCII_EN to enable the scan-code to ASCII ROM.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_DECODE = 2'd2,
    ST_EMIT   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
    logic [7:0] ascii;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational US-layout scan-code set 2 to lowercase ASCII lookup.
// Unmapped codes return 8'h00. Only instantiated when PS2_KBD_ASCII_EN is defined.
module ps2_ascii_rom
  import ps2_kbd_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  // Letters, digits, space and enter; everything else maps to zero
  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: pops bytes from the ps2_keyboard FIFO, folds the
// E0/F0 prefixes into key events, tracks the held key and reports events on a
// valid/ready interface. Build option: PS2_KBD_ASCII_EN adds ASCII translation.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_brk,
  output logic             evt_rpt,
  output logic [7:0]       evt_ascii,
  output logic             held,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  ps2_state_t       state_reg, state_next;
  logic [7:0]       byte_q;
  logic             ext_f, brk_f;
  ps2_evt_t         evt_reg;
  logic             evt_valid_reg;
  logic             nextdata_n_reg;
  logic             held_reg;
  logic [7:0]       held_code;
  logic             held_ext;
  logic [CNT_W-1:0] press_cnt_reg;
  logic             ovf_reg;
  logic [7:0]       ascii_lookup;
  logic             held_match;
  logic             rel_match;

`ifdef PS2_KBD_ASCII_EN
  logic [7:0] rom_ascii;

  ps2_ascii_rom u_ascii_rom (
    .code  (byte_q),
    .ascii (rom_ascii)
  );

  // Extended keys never carry a printable translation
  assign ascii_lookup = ext_f ? 8'h00 : rom_ascii;
`else
  assign ascii_lookup = 8'h00;
`endif

  // The byte being decoded repeats the currently held key
  assign held_match = held_reg && (held_code == byte_q) && (held_ext == ext_f);
  // The pending break event releases the currently held key
  assign rel_match  = held_reg && (held_code == evt_reg.code) && (held_ext == evt_reg.ext);

  // FSM state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: one byte per IDLE->POP->DECODE pass, EMIT waits for ready
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (kbd_ready) state_next = ST_POP;
      ST_POP:    state_next = ST_DECODE;
      ST_DECODE: begin
        if (byte_q == PS2_PFX_EXT || byte_q == PS2_PFX_BRK) state_next = ST_IDLE;
        else                                                state_next = ST_EMIT;
      end
      ST_EMIT:   if (evt_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Byte capture, prefix flags, event registers, held-key tracking and strobes
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      byte_q         <= 8'h00;
      ext_f          <= 1'b0;
      brk_f          <= 1'b0;
      evt_reg        <= '0;
      evt_valid_reg  <= 1'b0;
      nextdata_n_reg <= 1'b1;
      held_reg       <= 1'b0;
      held_code      <= 8'h00;
      held_ext       <= 1'b0;
      press_cnt_reg  <= '0;
    end else begin
      nextdata_n_reg <= (state_next != ST_POP);
      evt_valid_reg  <= (state_next == ST_EMIT);
      case (state_reg)
        ST_IDLE: if (kbd_ready) byte_q <= kbd_data;
        ST_DECODE: begin
          if (byte_q == PS2_PFX_EXT) begin
            ext_f <= 1'b1;
          end else if (byte_q == PS2_PFX_BRK) begin
            brk_f <= 1'b1;
          end else begin
            evt_reg.code  <= byte_q;
            evt_reg.ext   <= ext_f;
            evt_reg.brk   <= brk_f;
            evt_reg.rpt   <= !brk_f && held_match;
            evt_reg.ascii <= ascii_lookup;
          end
        end
        ST_EMIT: begin
          if (evt_ready) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
            if (evt_reg.brk) begin
              if (rel_match) held_reg <= 1'b0;
            end else if (!evt_reg.rpt) begin
              held_reg      <= 1'b1;
              held_code     <= evt_reg.code;
              held_ext      <= evt_reg.ext;
              press_cnt_reg <= press_cnt_reg + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)             ovf_reg <= 1'b0;
    else if (kbd_overflow) ovf_reg <= 1'b1;
    else if (ovf_clr)      ovf_reg <= 1'b0;
  end

  assign kbd_nextdata_n = nextdata_n_reg;
  assign evt_valid      = evt_valid_reg;
  assign evt_code       = evt_reg.code;
  assign evt_ext        = evt_reg.ext;
  assign evt_brk        = evt_reg.brk;
  assign evt_rpt        = evt_reg.rpt;
  assign evt_ascii      = evt_reg.ascii;
  assign held           = held_reg;
  assign press_cnt      = press_cnt_reg;
  assign ovf_sticky     = ovf_reg;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed testbench for ps2_kbd_ctrl with a small byte-FIFO model standing in
// for ps2_keyboard. Expected ASCII values follow PS2_KBD_ASCII_EN.
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       evt_rpt;
  logic [7:0] evt_ascii;
  logic       held;
  logic [7:0] press_cnt;
  logic       ovf_sticky;
  logic       ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] fifo_mem [0:31];
  logic [4:0] wr_ptr = 5'd0;
  logic [4:0] rd_ptr = 5'd0;
  int         pop_cnt = 0;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.CNT_W(8)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_code       (evt_code),
    .evt_ext        (evt_ext),
    .evt_brk        (evt_brk),
    .evt_rpt        (evt_rpt),
    .evt_ascii      (evt_ascii),
    .held           (held),
    .press_cnt      (press_cnt),
    .ovf_sticky     (ovf_sticky),
    .ovf_clr        (ovf_clr)
  );

  // FIFO model: head byte visible while non-empty, popped while the strobe is low
  assign kbd_ready = (wr_ptr != rd_ptr);
  assign kbd_data  = fifo_mem[rd_ptr];

  always @(negedge clk) begin
    if (clrn && !kbd_nextdata_n) begin
      rd_ptr  <= rd_ptr + 5'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  function automatic logic [7:0] asc(input logic [7:0] v);
`ifdef PS2_KBD_ASCII_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for an event, check its fields, then step past the accepting edge
  task automatic expect_evt(input string tag, input logic [7:0] code, input logic ext,
                            input logic brk, input logic rpt, input logic [7:0] ascii);
    for (int i = 0; i < 40 && !evt_valid; i++) tick();
    check({tag, "_valid"}, evt_valid, 1);
    check({tag, "_code"},  evt_code,  code);
    check({tag, "_ext"},   evt_ext,   ext);
    check({tag, "_brk"},   evt_brk,   brk);
    check({tag, "_rpt"},   evt_rpt,   rpt);
    check({tag, "_ascii"}, evt_ascii, ascii);
    $display("evt %s: code=%02h ext=%0d brk=%0d rpt=%0d ascii=%02h", tag,
             evt_code, evt_ext, evt_brk, evt_rpt, evt_ascii);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nextdata_n"}, kbd_nextdata_n, 1);
    check({tag, "_valid"},      evt_valid,      0);
    check({tag, "_code"},       evt_code,       0);
    check({tag, "_ext"},        evt_ext,        0);
    check({tag, "_brk"},        evt_brk,        0);
    check({tag, "_rpt"},        evt_rpt,        0);
    check({tag, "_ascii"},      evt_ascii,      0);
    check({tag, "_held"},       held,           0);
    check({tag, "_press"},      press_cnt,      0);
    check({tag, "_ovf"},        ovf_sticky,     0);
  endtask

  initial begin
    int n;
    clrn = 1'b0; evt_ready = 1'b1; kbd_overflow = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    clrn = 1'b1;
    tick();

    // 1: single make
    push(8'h1C);
    expect_evt("s1", 8'h1C, 0, 0, 0, asc(8'h61));
    check("s1_held", held, 1);
    check("s1_press", press_cnt, 1);
    check("s1_pops", pop_cnt, 1);
    repeat (4) tick();
    check("s1_single", evt_valid, 0);

    // 2: release
    push(8'hF0); push(8'h1C);
    expect_evt("s2", 8'h1C, 0, 1, 0, asc(8'h61));
    check("s2_held", held, 0);
    check("s2_press", press_cnt, 1);
    check("s2_pops", pop_cnt, 3);

    // 3: extended make then extended break
    push(8'hE0); push(8'h75);
    expect_evt("s3m", 8'h75, 1, 0, 0, 8'h00);
    check("s3m_held", held, 1);
    check("s3m_press", press_cnt, 2);
    push(8'hE0); push(8'hF0); push(8'h75);
    expect_evt("s3b", 8'h75, 1, 1, 0, 8'h00);
    check("s3b_held", held, 0);
    check("s3_pops", pop_cnt, 8);

    // 4: typematic repeats
    push(8'h1C); push(8'h1C); push(8'h1C);
    expect_evt("s4a", 8'h1C, 0, 0, 0, asc(8'h61));
    expect_evt("s4b", 8'h1C, 0, 0, 1, asc(8'h61));
    expect_evt("s4c", 8'h1C, 0, 0, 1, asc(8'h61));
    check("s4_press", press_cnt, 3);
    check("s4_held", held, 1);

    // Prefix folding: F0 E0 xx behaves as E0 F0 xx, duplicate prefixes are idempotent
    push(8'hE0); push(8'h14);
    expect_evt("pfx_m", 8'h14, 1, 0, 0, 8'h00);
    push(8'hF0); push(8'hF0); push(8'hE0); push(8'hE0); push(8'h14);
    expect_evt("pfx_b", 8'h14, 1, 1, 0, 8'h00);
    check("pfx_held", held, 0);
    check("pfx_press", press_cnt, 4);

    // 5: backpressure
    evt_ready = 1'b0;
    n = pop_cnt + 1;
    push(8'h29); push(8'h5A);
    for (int i = 0; i < 40 && !evt_valid; i++) tick();
    check("s5_valid", evt_valid, 1);
    check("s5_ascii", evt_ascii, asc(8'h20));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s5_hold_valid", evt_valid, 1);
      check("s5_hold_code", evt_code, 8'h29);
      check("s5_hold_nd", kbd_nextdata_n, 1);
    end
    check("s5_hold_pops", pop_cnt, n);
    evt_ready = 1'b1;
    tick();
    check("s5_drop", evt_valid, 0);
    n = 1;
    for (int i = 0; i < 20 && !evt_valid; i++) begin
      tick();
      n++;
    end
    check("s5_gap", n, 4);
    expect_evt("s5b", 8'h5A, 0, 0, 0, asc(8'h0D));
    check("s5_press", press_cnt, 6);

    // 6: overflow sticky behaviour
    kbd_overflow = 1'b1; tick(); kbd_overflow = 1'b0;
    check("ovf_set", ovf_sticky, 1);
    repeat (3) tick();
    check("ovf_hold", ovf_sticky, 1);
    kbd_overflow = 1'b1; ovf_clr = 1'b1; tick(); kbd_overflow = 1'b0; ovf_clr = 1'b0;
    check("ovf_both", ovf_sticky, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_clr", ovf_sticky, 0);
    kbd_overflow = 1'b1; tick(); kbd_overflow = 1'b0;
    check("ovf_reset", ovf_sticky, 1);

    // Reset asserted during EMIT forces reset values at once
    evt_ready = 1'b0;
    push(8'h1C);
    for (int i = 0; i < 40 && !evt_valid; i++) tick();
    check("emit_valid", evt_valid, 1);
    clrn = 1'b0;
    #1;
    check_reset_outputs("emit_rst");
    tick();
    clrn = 1'b1;
    evt_ready = 1'b1;
    repeat (4) tick();
    check("post_rst_idle", evt_valid, 0);

    // A pending prefix is discarded by reset
    push(8'hE0);
    repeat (5) tick();
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    push(8'h16);
    expect_evt("pfx_rst", 8'h16, 0, 0, 0, asc(8'h31));
    check("pfx_rst_press", press_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Controller that drains the `ps2_keyboard` receive FIFO through its `ready`/`nextdata_n` handshake and parses raw scan-code bytes into key events. It decodes the `E0` (extended) and `F0` (break) prefixes and tracks the currently held key. Events go downstream on a valid/ready interface. The block sits between `ps2_keyboard` and the top-level consumer, replacing ad-hoc byte polling.

## Interface
Parameters:
- `CNT_W`, default 8: width of the press counter.

Ports:
- `clk` in 1: single system clock.
- `clrn` in 1: asynchronous active-low reset.
- `kbd_data` in 8: FIFO head byte from `ps2_keyboard`.
- `kbd_ready` in 1: FIFO non-empty.
- `kbd_overflow` in 1: FIFO overflow flag.
- `kbd_nextdata_n` out 1: active-low pop strobe to `ps2_keyboard`.
- `evt_valid` out 1: event available.
- `evt_ready` in 1: consumer accepts the event.
- `evt_code` out 8: final (non-prefix) scan code.
- `evt_ext` out 1: an `E0` prefix preceded the code.
- `evt_brk` out 1: an `F0` prefix preceded the code (key release).
- `evt_rpt` out 1: typematic repeat of the held key.
- `evt_ascii` out 8: ASCII translation; `8'h00` if unmapped.
- `held` out 1: a key is currently held.
- `press_cnt` out CNT_W: count of accepted non-repeat make events.
- `ovf_sticky` out 1: latched FIFO overflow.
- `ovf_clr` in 1: clears `ovf_sticky`.

## Operation
FSM states: IDLE, POP, DECODE, EMIT.
- **IDLE:** when `kbd_ready`=1, register `kbd_data` into `byte_q` and go to POP.
- **POP:** `kbd_nextdata_n`=0 for exactly this one cycle. Go to DECODE.
- **DECODE:**
  - `byte_q`==`8'hE0`: set `ext_f`, go to IDLE.
  - `byte_q`==`8'hF0`: set `brk_f`, go to IDLE.
  - Otherwise: load the `evt_*` registers from `byte_q`, `ext_f` and `brk_f`, then go to EMIT.
- **EMIT:** `evt_valid`=1. All `evt_*` outputs stay stable until `evt_ready`=1. On the accepting edge: clear `ext_f`/`brk_f`, update held-key state, go to IDLE. No FIFO pops occur while in EMIT.

Held-key tracking (`held_code`, `held_ext`, `held`):
- Make with `held`=1 and a matching code/ext: `evt_rpt`=1; `press_cnt` does not increment.
- Any other make: `evt_rpt`=0. On accept, load `held_code`/`held_ext`, set `held`=1, `press_cnt`+1.
- `press_cnt` wraps modulo 2^CNT_W.
- Break matching `held_code`/`held_ext`: clears `held` on accept.
- Non-matching break: `held` is unchanged.
- Break events always have `evt_rpt`=0.

Overflow:
- `ovf_sticky` sets on any cycle with `kbd_overflow`=1.
- It clears on `ovf_clr`=1.
- If both occur in the same cycle, set wins.

Prefix boundary cases:
- A repeated prefix byte (`E0 E0`, `F0 F0`) leaves the flag set. It is idempotent.
- `F0 E0 xx` is accepted as equivalent to `E0 F0 xx`.

## Timing
- Reset values:
  - `kbd_nextdata_n`=1.
  - `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_brk`=0, `evt_rpt`=0, `evt_ascii`=0.
  - `held`=0, `press_cnt`=0, `ovf_sticky`=0.
  - Internal flags cleared; FSM in IDLE.
- All outputs are registered.
- Assertion of `clrn` at any time, including during EMIT, immediately forces the reset values. Any pending event or prefix is discarded.
- Sampling edge E (IDLE sees `kbd_ready`=1) → `kbd_nextdata_n` low during E..E+1 → DECODE during E+1..E+2 → `evt_valid` high after edge E+2.
- Each byte occupies at least 3 cycles. `kbd_ready` is not sampled again until IDLE, so it has settled after the pop.
- An event is accepted on the edge where `evt_valid`&`evt_ready`. `evt_valid` drops after that edge. The earliest next pop is sampled the following cycle.
- `evt_ready` may be held high permanently. Its value outside EMIT is ignored.

## Configuration
- `PS2_KBD_ASCII_EN` defined:
  - `ps2_ascii_rom` is instantiated. It maps US-layout set-2 codes to lowercase ASCII (letters, digits, space `8'h20`, enter `8'h0D`).
  - Extended codes and unmapped codes give `8'h00`.
- `PS2_KBD_ASCII_EN` undefined:
  - No ROM is instantiated.
  - `evt_ascii` is constant `8'h00`.
  - All other behaviour is identical.

## Structure
- Package `ps2_kbd_pkg` holds:
  - the FSM state enum;
  - `PS2_PFX_EXT`=`8'hE0` and `PS2_PFX_BRK`=`8'hF0`;
  - the `ps2_evt_t` struct (code, ext, brk, rpt, ascii).
- Sub-module `ps2_ascii_rom`: combinational 8-bit scan code → 8-bit ASCII lookup, registered into `evt_ascii` in DECODE.

## Test plan
1. **Single make:** FIFO holds `1C`, `evt_ready`=1 → one event with code `1C`, ext 0, brk 0, rpt 0, ascii `8'h61` (macro on) or `8'h00` (macro off). `held`=1, `press_cnt`=1. Exactly one `kbd_nextdata_n` low pulse.
2. **Release:** `F0 1C` after scenario 1 → one event with brk 1, code `1C`. `held`=0, `press_cnt` stays 1. Three pops total.
3. **Extended key:** `E0 75`, then `E0 F0 75` → events with ext 1, brk 0 and ext 1, brk 1. Ascii `8'h00`. `held` goes 1 then 0.
4. **Typematic:** `1C 1C 1C` → three events with rpt 0, 1, 1. `press_cnt`=1.
5. **Backpressure:** bytes `29` and `5A` queued, `evt_ready`=0 for 10 cycles → `evt_valid` stays high with code `29` stable and `kbd_nextdata_n` stays 1. After `evt_ready`=1, the `5A` event follows no earlier than 3 cycles later.
6. **Overflow and reset:** one-cycle `kbd_overflow` pulse → `ovf_sticky`=1 until `ovf_clr`. `ovf_clr` and `kbd_overflow` together → stays 1. `clrn` low during EMIT → all outputs at their reset values immediately.
